// File: rtl/xbar_sched_pkg.sv
// Shared sizing, arbiter state encoding and crossbar command indexing for the
// round-robin crossbar scheduler.
package xbar_sched_pkg;

    localparam int NUM_IN  = 16;
    localparam int NUM_OUT = 8;
    localparam int DEST_W  = 3;
    localparam int OWN_W   = $clog2(NUM_IN);

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Flat position of the routing bit for input n to output j in the command vector
    function automatic int idx(input int n, input int j);
        return n * NUM_OUT + j;
    endfunction

endpackage

// File: rtl/xbar_rr_out_arbiter.sv
// Per-output round-robin arbiter: picks one requester aimed at this output,
// holds it until its last beat, and releases it early if it stalls too long.
module xbar_rr_out_arbiter
    import xbar_sched_pkg::*;
#(
    parameter int OUT_IDX      = 0,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sched_en,
    input  logic [NUM_IN-1:0]        req,
    input  logic [NUM_IN*DEST_W-1:0] dest,
    input  logic [NUM_IN-1:0]        last,
    output logic [NUM_IN-1:0]        grant_col,
    output logic                     busy,
    output logic                     timeout
);

    localparam int                WD_W    = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(IDLE_TIMEOUT - 1);
    localparam logic [DEST_W-1:0] MY_DEST = DEST_W'(OUT_IDX);
    localparam logic [OWN_W-1:0]  OWN_MAX = OWN_W'(NUM_IN - 1);

    arb_state_e       state_q, state_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [OWN_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [OWN_W-1:0] owner_inc;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             timeout_q, timeout_d;
    logic [NUM_IN-1:0] cand;
    logic             found;
    logic [OWN_W-1:0] pick;

    // An input competes for this output when it requests with a matching destination
    always_comb begin
        cand = '0;
        for (int n = 0; n < NUM_IN; n++) begin
            cand[n] = req[n] && (dest[n*DEST_W +: DEST_W] == MY_DEST);
        end
    end

    // First candidate at or after the round-robin pointer, wrapping around
    always_comb begin
        int c;
        c     = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            c = (int'(rr_ptr_q) + k) % NUM_IN;
            if (!found && cand[c]) begin
                found = 1'b1;
                pick  = OWN_W'(c);
            end
        end
    end

    assign owner_inc = (owner_q == OWN_MAX) ? '0 : owner_q + 1'b1;

    // State, owner, pointer and watchdog registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    // Grant on an idle output, release on last beat or watchdog expiry
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        wd_d      = wd_q;
        timeout_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (sched_en && found) begin
                    state_d = ARB_BUSY;
                    owner_d = pick;
                    wd_d    = '0;
                end
            end
            ARB_BUSY: begin
                if (req[owner_q]) begin
                    wd_d = '0;
                    if (last[owner_q]) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = owner_inc;
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d   = ARB_IDLE;
                    rr_ptr_d  = owner_inc;
                    wd_d      = '0;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // One-hot grant column for the current owner while busy
    always_comb begin
        grant_col          = '0;
        grant_col[owner_q] = (state_q == ARB_BUSY);
    end

    assign busy    = (state_q == ARB_BUSY);
    assign timeout = timeout_q;

endmodule

// File: rtl/xbar_rr_scheduler.sv
// Round-robin scheduler for the 16-in/8-out one-hot crossbar: one arbiter per
// output, combined into requester grants and the crossbar command vector.
module xbar_rr_scheduler
    import xbar_sched_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_sched_en,
    input  logic [NUM_IN-1:0]         i_req,
    input  logic [NUM_IN*DEST_W-1:0]  i_dest,
    input  logic [NUM_IN-1:0]         i_last,
    output logic [NUM_IN-1:0]         o_grant,
    output logic [NUM_IN*NUM_OUT-1:0] o_cmd,
    output logic                      o_xbar_en,
    output logic [NUM_OUT-1:0]        o_busy,
    output logic [NUM_OUT-1:0]        o_timeout
);

    logic [NUM_IN-1:0] grant_cols [NUM_OUT];

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_arb
        xbar_rr_out_arbiter #(
            .OUT_IDX      (j),
            .IDLE_TIMEOUT (IDLE_TIMEOUT)
        ) u_arb (
            .clk       (clk),
            .rst_n     (rst_n),
            .sched_en  (i_sched_en),
            .req       (i_req),
            .dest      (i_dest),
            .last      (i_last),
            .grant_col (grant_cols[j]),
            .busy      (o_busy[j]),
            .timeout   (o_timeout[j])
        );
    end

    // Merge per-output grant columns into requester grants and crossbar commands
    always_comb begin
        o_grant = '0;
        o_cmd   = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            for (int n = 0; n < NUM_IN; n++) begin
                o_grant[n]       = o_grant[n] | grant_cols[j][n];
                o_cmd[idx(n, j)] = grant_cols[j][n];
            end
        end
    end

    // Crossbar stays enabled while scheduling is allowed or any output is owned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_xbar_en <= 1'b0;
        end else begin
            o_xbar_en <= i_sched_en | (|o_busy);
        end
    end

endmodule

// File: tb/tb_xbar_rr_scheduler.sv
// Directed testbench for the round-robin crossbar scheduler.
`timescale 1ns/1ps
module tb_xbar_rr_scheduler;

    localparam int NI = 16;
    localparam int NO = 8;
    localparam int DW = 3;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            sched_en;
    logic [NI-1:0]   req;
    logic [NI-1:0]   last;
    logic [NI*DW-1:0] dest;
    logic [NI-1:0]   grant;
    logic [NI*NO-1:0] cmd;
    logic            xbar_en;
    logic [NO-1:0]   busy;
    logic [NO-1:0]   timeout;

    int errors = 0;
    int checks = 0;

    xbar_rr_scheduler #(.IDLE_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sched_en (sched_en),
        .i_req      (req),
        .i_dest     (dest),
        .i_last     (last),
        .o_grant    (grant),
        .o_cmd      (cmd),
        .o_xbar_en  (xbar_en),
        .o_busy     (busy),
        .o_timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dest(input int n, input int d);
        dest[n*DW +: DW] = DW'(d);
    endtask

    task automatic reset_dut();
        rst_n    = 1'b0;
        sched_en = 1'b0;
        req      = '0;
        last     = '0;
        dest     = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        sched_en = 1'b0;
        req      = '0;
        last     = '0;
        dest     = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (grant !== '0)   begin errors++; $display("[TB] FAIL reset_grant: got %h expected 0", grant); end
        checks++; if (cmd !== '0)     begin errors++; $display("[TB] FAIL reset_cmd: got %h expected 0", cmd); end
        checks++; if (busy !== '0)    begin errors++; $display("[TB] FAIL reset_busy: got %h expected 0", busy); end
        checks++; if (timeout !== '0) begin errors++; $display("[TB] FAIL reset_timeout: got %h expected 0", timeout); end
        checks++; if (xbar_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_xbar_en: got %b expected 0", xbar_en); end
        #2 rst_n = 1'b1;
        tick();
        tick();
        checks++; if (xbar_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_xbar_en: got %b expected 0", xbar_en); end
        checks++; if (busy !== '0)      begin errors++; $display("[TB] FAIL reset_release_busy: got %h expected 0", busy); end
    endtask

    task automatic test_single_request();
        logic [NI*NO-1:0] exp_c;
        reset_dut();
        sched_en = 1'b1;
        req[5]   = 1'b1;
        last[5]  = 1'b1;
        set_dest(5, 3);
        checks++; if (grant !== '0) begin errors++; $display("[TB] FAIL single_c0_grant: got %h expected 0", grant); end
        tick();
        exp_c     = '0;
        exp_c[43] = 1'b1;
        checks++; if (grant !== 16'h0020) begin errors++; $display("[TB] FAIL single_c1_grant: got %h expected 0020", grant); end
        checks++; if (cmd !== exp_c)      begin errors++; $display("[TB] FAIL single_c1_cmd: got %h expected %h", cmd, exp_c); end
        checks++; if (busy !== 8'h08)     begin errors++; $display("[TB] FAIL single_c1_busy: got %h expected 08", busy); end
        tick();
        req  = '0;
        last = '0;
        checks++; if (grant !== '0)     begin errors++; $display("[TB] FAIL single_c2_grant: got %h expected 0", grant); end
        checks++; if (cmd !== '0)       begin errors++; $display("[TB] FAIL single_c2_cmd: got %h expected 0", cmd); end
        checks++; if (busy[3] !== 1'b0) begin errors++; $display("[TB] FAIL single_c2_busy: got %b expected 0", busy[3]); end
    endtask

    task automatic test_contention();
        int own_tab [4] = '{2, 9, 14, 2};
        logic [NI-1:0]    exp_g;
        logic [NI*NO-1:0] exp_c;
        reset_dut();
        sched_en = 1'b1;
        req[2] = 1'b1; req[9] = 1'b1; req[14] = 1'b1;
        set_dest(2, 6); set_dest(9, 6); set_dest(14, 6);
        for (int c = 1; c <= 19; c++) begin
            int seg;
            int pos;
            tick();
            seg   = (c - 1) / 5;
            pos   = (c - 1) % 5;
            exp_g = '0;
            exp_c = '0;
            last  = '0;
            if (pos != 4) begin
                exp_g[own_tab[seg]]          = 1'b1;
                exp_c[own_tab[seg] * NO + 6] = 1'b1;
            end
            if (pos == 3) last[own_tab[seg]] = 1'b1;
            checks++; if (grant !== exp_g) begin errors++; $display("[TB] FAIL contention_grant c%0d: got %h expected %h", c, grant, exp_g); end
            checks++; if (cmd !== exp_c)   begin errors++; $display("[TB] FAIL contention_cmd c%0d: got %h expected %h", c, cmd, exp_c); end
            checks++; if (busy[6] !== (pos != 4)) begin errors++; $display("[TB] FAIL contention_busy c%0d: got %b expected %b", c, busy[6], (pos != 4)); end
        end
        tick();
        req  = '0;
        last = '0;
    endtask

    task automatic test_parallel();
        logic [NI*NO-1:0] exp_c;
        reset_dut();
        sched_en = 1'b1;
        exp_c    = '0;
        for (int n = 0; n < 8; n++) begin
            req[n]  = 1'b1;
            last[n] = 1'b1;
            set_dest(n, 7 - n);
            exp_c[n * NO + (7 - n)] = 1'b1;
        end
        tick();
        checks++; if (grant !== 16'h00FF) begin errors++; $display("[TB] FAIL parallel_grant: got %h expected 00ff", grant); end
        checks++; if (cmd !== exp_c)      begin errors++; $display("[TB] FAIL parallel_cmd: got %h expected %h", cmd, exp_c); end
        checks++; if (busy !== 8'hFF)     begin errors++; $display("[TB] FAIL parallel_busy: got %h expected ff", busy); end
        checks++; if ($countones(cmd) != 8) begin errors++; $display("[TB] FAIL parallel_cmd_ones: got %0d expected 8", $countones(cmd)); end
        tick();
        req  = '0;
        last = '0;
        checks++; if (busy !== '0) begin errors++; $display("[TB] FAIL parallel_release_busy: got %h expected 0", busy); end
    endtask

    task automatic test_stall_timeout();
        reset_dut();
        sched_en = 1'b1;
        req[1]   = 1'b1;
        set_dest(1, 0);
        tick();
        req[1] = 1'b0;
        checks++; if (grant !== 16'h0002) begin errors++; $display("[TB] FAIL stall_c1_grant: got %h expected 0002", grant); end
        for (int c = 2; c <= 8; c++) begin
            tick();
            req[1] = (c == 4);
            checks++; if (grant !== 16'h0002) begin errors++; $display("[TB] FAIL stall_hold_grant c%0d: got %h expected 0002", c, grant); end
            checks++; if (timeout !== '0)     begin errors++; $display("[TB] FAIL stall_early_timeout c%0d: got %h expected 0", c, timeout); end
        end
        tick();
        checks++; if (grant !== '0)      begin errors++; $display("[TB] FAIL stall_c9_grant: got %h expected 0", grant); end
        checks++; if (timeout !== 8'h01) begin errors++; $display("[TB] FAIL stall_c9_timeout: got %h expected 01", timeout); end
        checks++; if (busy !== '0)       begin errors++; $display("[TB] FAIL stall_c9_busy: got %h expected 0", busy); end
        req[1]  = 1'b1;
        req[3]  = 1'b1;
        last[3] = 1'b1;
        set_dest(3, 0);
        tick();
        checks++; if (timeout !== '0)     begin errors++; $display("[TB] FAIL stall_c10_timeout: got %h expected 0", timeout); end
        checks++; if (grant !== 16'h0008) begin errors++; $display("[TB] FAIL stall_c10_rrptr_grant: got %h expected 0008", grant); end
        tick();
        req[3]  = 1'b0;
        last[3] = 1'b0;
        last[1] = 1'b1;
        checks++; if (grant !== '0) begin errors++; $display("[TB] FAIL stall_c11_idle_grant: got %h expected 0", grant); end
        tick();
        checks++; if (grant !== 16'h0002) begin errors++; $display("[TB] FAIL stall_c12_grant: got %h expected 0002", grant); end
        tick();
        req  = '0;
        last = '0;
    endtask

    task automatic test_gating();
        reset_dut();
        req[3] = 1'b1;
        set_dest(3, 2);
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++; if (grant !== '0)     begin errors++; $display("[TB] FAIL gating_off_grant c%0d: got %h expected 0", c, grant); end
            checks++; if (xbar_en !== 1'b0) begin errors++; $display("[TB] FAIL gating_off_xbar_en c%0d: got %b expected 0", c, xbar_en); end
        end
        sched_en = 1'b1;
        tick();
        sched_en = 1'b0;
        checks++; if (grant !== 16'h0008) begin errors++; $display("[TB] FAIL gating_c4_grant: got %h expected 0008", grant); end
        checks++; if (xbar_en !== 1'b1)   begin errors++; $display("[TB] FAIL gating_c4_xbar_en: got %b expected 1", xbar_en); end
        tick();
        checks++; if (grant !== 16'h0008) begin errors++; $display("[TB] FAIL gating_c5_grant: got %h expected 0008", grant); end
        checks++; if (xbar_en !== 1'b1)   begin errors++; $display("[TB] FAIL gating_c5_xbar_en: got %b expected 1", xbar_en); end
        tick();
        last[3] = 1'b1;
        checks++; if (grant !== 16'h0008) begin errors++; $display("[TB] FAIL gating_c6_grant: got %h expected 0008", grant); end
        tick();
        last[3] = 1'b0;
        checks++; if (grant !== '0)       begin errors++; $display("[TB] FAIL gating_c7_grant: got %h expected 0", grant); end
        checks++; if (busy[2] !== 1'b0)   begin errors++; $display("[TB] FAIL gating_c7_busy: got %b expected 0", busy[2]); end
        checks++; if (xbar_en !== 1'b1)   begin errors++; $display("[TB] FAIL gating_c7_xbar_en: got %b expected 1", xbar_en); end
        tick();
        checks++; if (grant !== '0)       begin errors++; $display("[TB] FAIL gating_c8_grant: got %h expected 0", grant); end
        checks++; if (xbar_en !== 1'b0)   begin errors++; $display("[TB] FAIL gating_c8_xbar_en: got %b expected 0", xbar_en); end
        req = '0;
    endtask

    task automatic test_reset_midburst();
        logic [NI*NO-1:0] exp_c;
        reset_dut();
        sched_en = 1'b1;
        req[12]  = 1'b1;
        last[12] = 1'b1;
        set_dest(12, 5);
        tick();
        checks++; if (grant !== 16'h1000) begin errors++; $display("[TB] FAIL midrst_first_grant: got %h expected 1000", grant); end
        tick();
        req      = '0;
        last     = '0;
        req[14]  = 1'b1;
        set_dest(14, 5);
        tick();
        checks++; if (grant !== 16'h4000) begin errors++; $display("[TB] FAIL midrst_second_grant: got %h expected 4000", grant); end
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (grant !== '0)   begin errors++; $display("[TB] FAIL midrst_async_grant: got %h expected 0", grant); end
        checks++; if (cmd !== '0)     begin errors++; $display("[TB] FAIL midrst_async_cmd: got %h expected 0", cmd); end
        checks++; if (busy !== '0)    begin errors++; $display("[TB] FAIL midrst_async_busy: got %h expected 0", busy); end
        checks++; if (timeout !== '0) begin errors++; $display("[TB] FAIL midrst_async_timeout: got %h expected 0", timeout); end
        req  = '0;
        last = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        req[10]  = 1'b1;
        req[14]  = 1'b1;
        last[10] = 1'b1;
        last[14] = 1'b1;
        set_dest(10, 5);
        set_dest(14, 5);
        tick();
        exp_c     = '0;
        exp_c[85] = 1'b1;
        checks++; if (grant !== 16'h0400) begin errors++; $display("[TB] FAIL midrst_rearb_grant: got %h expected 0400", grant); end
        checks++; if (cmd !== exp_c)      begin errors++; $display("[TB] FAIL midrst_rearb_cmd: got %h expected %h", cmd, exp_c); end
        tick();
        req  = '0;
        last = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL sim_time_limit: run did not complete, expected finish before 200000 ns");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        test_reset();
        test_single_request();
        test_contention();
        test_parallel();
        test_stall_timeout();
        test_gating();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
